// File: rtl/btb_pkg.sv
// Shared constants for the branch target buffer: 2-bit counter encodings,
// default geometry and a saturating statistics increment.
package btb_pkg;

  localparam int BTB_AW      = 12;
  localparam int BTB_ENTRIES = 16;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic inc);
    logic [15:0] r;
    if (inc && (v != 16'hFFFF)) begin
      r = v + 16'd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Next-state logic for a 2-bit saturating branch direction counter.
module sat_ctr2
  import btb_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next_ctr
);

  // Step toward strongly-taken or strongly-not-taken, holding at the ends.
  always_comb begin
    next_ctr = CTR_SNT;
    case (ctr)
      CTR_SNT: next_ctr = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: next_ctr = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  next_ctr = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  next_ctr = taken ? CTR_ST  : CTR_WT;
      default: next_ctr = CTR_SNT;
    endcase
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters and
// saturating branch / mispredict statistics.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int AW      = BTB_AW
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic [AW-1:0] IF_PC,
  output logic          pred_valid,
  output logic          pred_taken,
  output logic [AW-1:0] pred_target,
  input  logic          upd_en,
  input  logic [AW-1:0] upd_pc,
  input  logic          upd_taken,
  input  logic [AW-1:0] upd_target,
  input  logic          upd_pred_valid,
  input  logic          upd_pred_taken,
  output logic [15:0]   stat_branches,
  output logic [15:0]   stat_mispredicts
);

  localparam int IDX = $clog2(ENTRIES);
  localparam int TW  = AW - IDX - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         ctr_q [ENTRIES];
  logic [1:0]         ctr_d [ENTRIES];
  logic [TW-1:0]      tag_q [ENTRIES];
  logic [AW-1:0]      tgt_q [ENTRIES];
  logic [15:0]        branches_q, branches_d;
  logic [15:0]        mispredicts_q, mispredicts_d;

  logic [IDX-1:0] if_idx, upd_idx;
  logic [TW-1:0]  if_tag, upd_tag;
  logic           if_hit, upd_hit, mispredict;
  logic [1:0]     ctr_step;
  logic           unused_pc_bits;

  assign if_idx  = IF_PC[IDX+1:2];
  assign if_tag  = IF_PC[AW-1:IDX+2];
  assign upd_idx = upd_pc[IDX+1:2];
  assign upd_tag = upd_pc[AW-1:IDX+2];
  assign unused_pc_bits = ^{IF_PC[1:0], upd_pc[1:0]};

  assign if_hit  = valid_q[if_idx]  && (tag_q[if_idx]  == if_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mispredict = (~upd_pred_valid & upd_taken) |
                      (upd_pred_valid & (upd_pred_taken != upd_taken));

  sat_ctr2 u_sat_ctr2 (
    .ctr      (ctr_q[upd_idx]),
    .taken    (upd_taken),
    .next_ctr (ctr_step)
  );

  // Fetch-side lookup reads registered state only, so a same-cycle update is not bypassed.
  always_comb begin
    pred_valid  = if_hit;
    pred_taken  = 1'b0;
    pred_target = {AW{1'b0}};
    if (if_hit) begin
      pred_taken  = ctr_q[if_idx][1];
      pred_target = tgt_q[if_idx];
    end else begin
      pred_taken  = 1'b0;
      pred_target = {AW{1'b0}};
    end
  end

  // Resolution: step counter on hit, allocate at weakly-taken on a taken miss.
  always_comb begin
    valid_d       = valid_q;
    ctr_d         = ctr_q;
    branches_d    = sat_inc16(branches_q, upd_en);
    mispredicts_d = sat_inc16(mispredicts_q, upd_en & mispredict);
    if (upd_en && upd_hit) begin
      ctr_d[upd_idx] = ctr_step;
    end else if (upd_en && upd_taken) begin
      valid_d[upd_idx] = 1'b1;
      ctr_d[upd_idx]   = CTR_WT;
    end else begin
      valid_d = valid_q;
      ctr_d   = ctr_q;
    end
  end

  // Valid bits, counters and statistics; synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      valid_q       <= {ENTRIES{1'b0}};
      branches_q    <= 16'd0;
      mispredicts_q <= 16'd0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_SNT;
      end
    end else begin
      valid_q       <= valid_d;
      ctr_q         <= ctr_d;
      branches_q    <= branches_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  // Tag/target storage is unreset; a taken resolution rewrites both (tag is unchanged on a hit).
  always_ff @(posedge CLK) begin
    if (RSTn && upd_en && upd_taken) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target;
    end
  end

  assign stat_branches    = branches_q;
  assign stat_mispredicts = mispredicts_q;

endmodule

// File: tb/tb_btb_predictor.sv
// Directed and randomized checks of btb_predictor against an array-based reference model.
module tb_btb_predictor;

  logic        CLK;
  logic        RSTn;
  logic [11:0] IF_PC;
  logic        pred_valid, pred_taken;
  logic [11:0] pred_target;
  logic        upd_en, upd_taken, upd_pred_valid, upd_pred_taken;
  logic [11:0] upd_pc, upd_target;
  logic [15:0] stat_branches, stat_mispredicts;

  int n_checks = 0;
  int n_errors = 0;

  int m_valid [16];
  int m_tag   [16];
  int m_tgt   [16];
  int m_ctr   [16];
  int m_br, m_mp;

  logic [11:0] pool [8];

  btb_predictor dut (
    .CLK(CLK), .RSTn(RSTn), .IF_PC(IF_PC),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_valid(upd_pred_valid), .upd_pred_taken(upd_pred_taken),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int m_index(input int pc);
    return (pc >> 2) % 16;
  endfunction

  function automatic int m_tagof(input int pc);
    return pc >> 6;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  task automatic model_update(input int upc, input int ut, input int utgt, input int upv, input int upt);
    int  i;
    int  t;
    bit  hit;
    bit  misp;
    i    = m_index(upc);
    t    = m_tagof(upc);
    hit  = (m_valid[i] != 0) && (m_tag[i] == t);
    misp = (upv != 0) ? (upt != ut) : (ut != 0);
    m_br = (m_br < 65535) ? m_br + 1 : 65535;
    if (misp) m_mp = (m_mp < 65535) ? m_mp + 1 : 65535;
    if (hit) begin
      m_ctr[i] = (ut != 0) ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                           : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
      if (ut != 0) m_tgt[i] = utgt;
    end else if (ut != 0) begin
      m_valid[i] = 1;
      m_tag[i]   = t;
      m_tgt[i]   = utgt;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic check_lookup(input int pc);
    int i;
    bit hit;
    i   = m_index(pc);
    hit = (m_valid[i] != 0) && (m_tag[i] == m_tagof(pc));
    chk("lookup_valid", {31'd0, pred_valid}, {31'd0, hit});
    chk("lookup_taken", {31'd0, pred_taken}, {31'd0, hit && (m_ctr[i] >= 2)});
    chk("lookup_target", {20'd0, pred_target}, hit ? m_tgt[i] : 0);
  endtask

  task automatic check_stats();
    chk("stat_branches", {16'd0, stat_branches}, m_br);
    chk("stat_mispredicts", {16'd0, stat_mispredicts}, m_mp);
  endtask

  // One clock: drive, check lookup against pre-edge state, clock, check statistics.
  task automatic cycle(input logic [11:0] pc, input logic en, input logic [11:0] upc,
                       input logic ut, input logic [11:0] utgt, input logic upv,
                       input logic upt, input logic rst);
    IF_PC = pc; upd_en = en; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_valid = upv; upd_pred_taken = upt; RSTn = ~rst;
    #1;
    check_lookup(int'(pc));
    @(posedge CLK);
    if (rst) model_reset();
    else if (en) model_update(int'(upc), int'(ut), int'(utgt), int'(upv), int'(upt));
    #1;
    check_stats();
  endtask

  initial begin
    CLK = 1'b0; RSTn = 1'b0; IF_PC = 12'h040;
    upd_en = 1'b1; upd_pc = 12'h040; upd_taken = 1'b1; upd_target = 12'h0AA;
    upd_pred_valid = 1'b0; upd_pred_taken = 1'b0;
    repeat (2) @(posedge CLK);
    model_reset();
    #1;

    // Reset state with updates held off by RSTn.
    cycle(12'h040, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    chk("r33_valid", {31'd0, pred_valid}, 32'd0);
    chk("r33_target", {20'd0, pred_target}, 32'd0);
    chk("r33_branches", {16'd0, stat_branches}, 32'd0);

    // Allocate on a taken miss.
    cycle(12'h040, 1'b1, 12'h040, 1'b1, 12'h100, 1'b0, 1'b0, 1'b0);
    chk("r34_valid", {31'd0, pred_valid}, 32'd1);
    chk("r34_taken", {31'd0, pred_taken}, 32'd1);
    chk("r34_target", {20'd0, pred_target}, 32'h100);
    chk("r34_mispredicts", {16'd0, stat_mispredicts}, 32'd1);

    // Decrement WT -> WNT -> SNT, then hold at SNT.
    cycle(12'h040, 1'b1, 12'h040, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
    cycle(12'h040, 1'b1, 12'h040, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
    chk("r35_valid", {31'd0, pred_valid}, 32'd1);
    chk("r35_taken", {31'd0, pred_taken}, 32'd0);
    cycle(12'h040, 1'b1, 12'h040, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
    cycle(12'h040, 1'b1, 12'h040, 1'b1, 12'h104, 1'b1, 1'b0, 1'b0);
    chk("r35_sat_taken", {31'd0, pred_taken}, 32'd0);
    chk("r35_target", {20'd0, pred_target}, 32'h104);

    // Alias at the same index with a different tag replaces the occupant.
    cycle(12'h440, 1'b1, 12'h440, 1'b1, 12'h200, 1'b0, 1'b0, 1'b0);
    chk("r36_new_hit", {31'd0, pred_valid}, 32'd1);
    chk("r36_new_target", {20'd0, pred_target}, 32'h200);
    cycle(12'h040, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
    chk("r36_old_miss", {31'd0, pred_valid}, 32'd0);

    // Same-cycle lookup and update: old entry before the edge, new one after.
    IF_PC = 12'h440; upd_en = 1'b1; upd_pc = 12'h440; upd_taken = 1'b1; upd_target = 12'h300;
    upd_pred_valid = 1'b1; upd_pred_taken = 1'b1; RSTn = 1'b1;
    #1;
    chk("r37_old_target", {20'd0, pred_target}, 32'h200);
    cycle(12'h440, 1'b1, 12'h440, 1'b1, 12'h300, 1'b1, 1'b1, 1'b0);
    chk("r37_new_target", {20'd0, pred_target}, 32'h300);

    // Randomized traffic over a small PC pool with deliberate aliases and mid-stream resets.
    for (int k = 0; k < 4; k++) begin
      pool[k]     = 12'($urandom_range(0, 4095));
      pool[k + 4] = pool[k] ^ 12'h400;
    end
    for (int n = 0; n < 400; n++) begin
      cycle(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 3) != 0),
            pool[$urandom_range(0, 7)], 1'($urandom), 12'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 39) == 0));
    end

    // Drive the statistics to saturation with mispredicted updates.
    IF_PC = 12'h080; upd_en = 1'b1; upd_pc = 12'h080; upd_taken = 1'b1; upd_target = 12'h3F0;
    upd_pred_valid = 1'b0; upd_pred_taken = 1'b0; RSTn = 1'b1;
    for (int n = 0; n < 65540; n++) begin
      @(posedge CLK);
      model_update(32'h080, 1, 32'h3F0, 0, 0);
    end
    #1;
    check_stats();
    chk("r38_mp_sat", {16'd0, stat_mispredicts}, 32'hFFFF);
    chk("r38_br_sat", {16'd0, stat_branches}, 32'hFFFF);

    // Reset with a coincident update: everything cleared, update discarded.
    cycle(12'h080, 1'b1, 12'h0C0, 1'b1, 12'h111, 1'b0, 1'b0, 1'b1);
    chk("r38_rst_mp", {16'd0, stat_mispredicts}, 32'd0);
    chk("r38_rst_br", {16'd0, stat_branches}, 32'd0);
    RSTn = 1'b1; upd_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      IF_PC = 12'(i << 2) | pool[i % 8] & 12'hFC3;
      #1;
      chk("r38_rst_invalid", {31'd0, pred_valid}, 32'd0);
      chk("r38_rst_target", {20'd0, pred_target}, 32'd0);
    end
    IF_PC = 12'h0C0;
    #1;
    chk("r30_discarded", {31'd0, pred_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
